// File: rtl/bsg_cache_dma_sram_responder.sv
// bsg_cache_dma_sram_responder
// Memory-side responder for the bsg_cache DMA interface, backed by an
// internal word memory (async read, sync write, not cleared on reset).
// A read packet streams one block out on dma_data_o; a write packet absorbs
// one block from dma_data_i. One packet is in flight at a time.
// Optional feature macro: BSG_CACHE_DMA_RESP_WRITE_MASK_EN -- when defined,
// write words whose packet mask bit is 0 are consumed but not stored.
module bsg_cache_dma_sram_responder #(
  parameter int addr_width_p          = 30,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int els_p                 = 8192,
  parameter int dma_pkt_width_lp      = 1 + block_size_in_words_p + addr_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,
  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_i,
  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o
);

  localparam int lg_els_lp      = $clog2(els_p);
  localparam int lg_block_lp    = $clog2(block_size_in_words_p);
  localparam int byte_offset_lp = $clog2(data_width_p / 8);
  localparam logic [lg_block_lp-1:0] last_cnt_lp = lg_block_lp'(block_size_in_words_p - 1);
  localparam logic [lg_els_lp-1:0]   blk_low_lp  = lg_els_lp'(block_size_in_words_p - 1);

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_read  = 2'd1,
    e_write = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [lg_block_lp-1:0]         cnt_q, cnt_d;
  logic [lg_els_lp-1:0]           base_q, base_d;
  logic [block_size_in_words_p-1:0] mask_q, mask_d;
  logic [data_width_p-1:0]        mem_q [els_p];

  logic                           pkt_yumi_s;
  logic                           data_v_s;
  logic                           data_yumi_s;
  logic                           mem_we_s;

  // Packet field extraction: {write_not_read, mask, addr}, MSB first.
  logic                             pkt_write_s;
  logic [block_size_in_words_p-1:0] pkt_mask_s;
  logic [addr_width_p-1:0]          pkt_addr_s;
  logic [addr_width_p-1:0]          addr_words_s;
  logic [lg_els_lp-1:0]             pkt_base_s;
  logic [lg_els_lp-1:0]             word_idx_s;
  logic                             unused_s;

  assign pkt_write_s  = dma_pkt_i[addr_width_p + block_size_in_words_p];
  assign pkt_mask_s   = dma_pkt_i[addr_width_p +: block_size_in_words_p];
  assign pkt_addr_s   = dma_pkt_i[addr_width_p-1:0];
  // Byte address to word index, wrapping modulo the memory depth.
  assign addr_words_s = pkt_addr_s >> byte_offset_lp;
  assign pkt_base_s   = addr_words_s[lg_els_lp-1:0] & ~blk_low_lp;
  // Blocks are aligned, so base + cnt never carries past the block.
  assign word_idx_s   = base_q + lg_els_lp'(cnt_q);
  // Upper address bits and (in the default build) the mask are intentionally dropped.
  assign unused_s     = ^{addr_words_s, mask_q};

  // Next-state and handshake logic for the IDLE/READ/WRITE transfer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    mask_d      = mask_q;
    pkt_yumi_s  = 1'b0;
    data_v_s    = 1'b0;
    data_yumi_s = 1'b0;
    mem_we_s    = 1'b0;
    if (reset_i) begin
      state_d = e_idle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        e_idle: begin
          pkt_yumi_s = dma_pkt_v_i;
          if (dma_pkt_v_i) begin
            base_d  = pkt_base_s;
            mask_d  = pkt_mask_s;
            cnt_d   = '0;
            state_d = pkt_write_s ? e_write : e_read;
          end else begin
            state_d = e_idle;
          end
        end
        e_read: begin
          data_v_s = 1'b1;
          if (dma_data_ready_i) begin
            cnt_d   = cnt_q + lg_block_lp'(1);
            state_d = (cnt_q == last_cnt_lp) ? e_idle : e_read;
          end else begin
            state_d = e_read;
          end
        end
        e_write: begin
          data_yumi_s = dma_data_v_i;
          if (dma_data_v_i) begin
`ifdef BSG_CACHE_DMA_RESP_WRITE_MASK_EN
            mem_we_s = mask_q[cnt_q];
`else
            mem_we_s = 1'b1;
`endif
            cnt_d   = cnt_q + lg_block_lp'(1);
            state_d = (cnt_q == last_cnt_lp) ? e_idle : e_write;
          end else begin
            state_d = e_write;
          end
        end
        default: begin
          state_d = e_idle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state, word counter and latched packet fields.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
    end
  end

  // Backing store write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[word_idx_s] <= dma_data_i;
    end
  end

  assign dma_pkt_yumi_o  = pkt_yumi_s;
  assign dma_data_v_o    = data_v_s;
  assign dma_data_yumi_o = data_yumi_s;
  assign dma_data_o      = mem_q[word_idx_s];

endmodule

// File: tb/tb_bsg_cache_dma_sram_responder.sv
// Directed testbench for bsg_cache_dma_sram_responder (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_bsg_cache_dma_sram_responder;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BS = 8;
  localparam int ELS = 8192;
  localparam int PW = 1 + BS + AW;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [PW-1:0] dma_pkt_i;
  logic          dma_pkt_v_i;
  logic          dma_pkt_yumi_o;
  logic [DW-1:0] dma_data_o;
  logic          dma_data_v_o;
  logic          dma_data_ready_i;
  logic [DW-1:0] dma_data_i;
  logic          dma_data_v_i;
  logic          dma_data_yumi_o;

  int check_cnt = 0;
  int err_cnt   = 0;

  logic [DW-1:0] wr_words  [BS];
  logic [DW-1:0] exp_words [BS];

  always #5 clk_i = ~clk_i;

  bsg_cache_dma_sram_responder #(
    .addr_width_p          (AW),
    .data_width_p          (DW),
    .block_size_in_words_p (BS),
    .els_p                 (ELS)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .dma_pkt_i        (dma_pkt_i),
    .dma_pkt_v_i      (dma_pkt_v_i),
    .dma_pkt_yumi_o   (dma_pkt_yumi_o),
    .dma_data_o       (dma_data_o),
    .dma_data_v_o     (dma_data_v_o),
    .dma_data_ready_i (dma_data_ready_i),
    .dma_data_i       (dma_data_i),
    .dma_data_v_i     (dma_data_v_i),
    .dma_data_yumi_o  (dma_data_yumi_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send_pkt(input logic wnr, input logic [BS-1:0] mask, input logic [AW-1:0] addr);
    dma_pkt_i   = {wnr, mask, addr};
    dma_pkt_v_i = 1'b1;
    #1;
    check_val("pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
    check_val("accept_no_rd_v", 64'(dma_data_v_o), 64'd0);
    step();
    dma_pkt_v_i = 1'b0;
  endtask

  task automatic write_block(input logic [AW-1:0] addr, input logic [BS-1:0] mask);
    send_pkt(1'b1, mask, addr);
    for (int i = 0; i < BS; i++) begin
      dma_data_i   = wr_words[i];
      dma_data_v_i = 1'b1;
      #1;
      check_val("wr_yumi", 64'(dma_data_yumi_o), 64'd1);
      step();
    end
    dma_data_v_i = 1'b0;
  endtask

  // Drains one read block; stall selects the ready pattern 1,0,0,...
  task automatic read_words(input bit stall, input int first);
    int n;
    n = first;
    for (int cyc = 0; cyc < 40 && n < BS; cyc++) begin
      dma_data_ready_i = stall ? ((cyc % 3) == 0) : 1'b1;
      #1;
      check_val("rd_v", 64'(dma_data_v_o), 64'd1);
      check_val("rd_data", 64'(dma_data_o), 64'(exp_words[n]));
      if (dma_data_ready_i) n++;
      step();
    end
    dma_data_ready_i = 1'b0;
    check_val("rd_count", 64'(n), 64'(BS));
    #1;
    check_val("rd_done_v", 64'(dma_data_v_o), 64'd0);
  endtask

  task automatic read_block(input logic [AW-1:0] addr, input bit stall);
    send_pkt(1'b0, 8'hFF, addr);
    read_words(stall, 0);
    @(negedge clk_i);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i          = 1'b1;
    dma_pkt_i        = '0;
    dma_pkt_v_i      = 1'b1;
    dma_data_ready_i = 1'b1;
    dma_data_i       = 32'h0;
    dma_data_v_i     = 1'b1;
    @(negedge clk_i);
    step();
    #1;
    check_val("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    check_val("rst_data_v", 64'(dma_data_v_o), 64'd0);
    check_val("rst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
    @(negedge clk_i);
    reset_i      = 1'b0;
    dma_pkt_v_i  = 1'b0;
    dma_data_v_i = 1'b0;
    #1;
    check_val("idle_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    @(negedge clk_i);

    // Write then read at 0x40.
    for (int i = 0; i < BS; i++) wr_words[i] = 32'h10 + 32'(i);
    write_block(30'h40, 8'hFF);
    for (int i = 0; i < BS; i++) exp_words[i] = 32'h10 + 32'(i);
    read_block(30'h40, 1'b0);

    // Read with backpressure.
    read_block(30'h40, 1'b1);

    // Masked write over a preloaded block.
    for (int i = 0; i < BS; i++) wr_words[i] = 32'hAA;
    write_block(30'h80, 8'hFF);
    for (int i = 0; i < BS; i++) wr_words[i] = 32'h55;
    write_block(30'h80, 8'h0F);
`ifdef BSG_CACHE_DMA_RESP_WRITE_MASK_EN
    for (int i = 0; i < BS; i++) exp_words[i] = (i < 4) ? 32'h55 : 32'hAA;
`else
    for (int i = 0; i < BS; i++) exp_words[i] = 32'h55;
`endif
    read_block(30'h80, 1'b0);

    // 0x8044 wraps onto word indices 0x10..0x17, same block as 0x40.
    for (int i = 0; i < BS; i++) wr_words[i] = 32'h100 + 32'(i);
    write_block(30'h8044, 8'hFF);
    for (int i = 0; i < BS; i++) exp_words[i] = 32'h100 + 32'(i);
    read_block(30'h40, 1'b0);
    read_block(30'h8044, 1'b0);

    // Reset after 3 of 8 read words.
    send_pkt(1'b0, 8'hFF, 30'h40);
    for (int i = 0; i < 3; i++) begin
      dma_data_ready_i = 1'b1;
      #1;
      check_val("pre_rst_data", 64'(dma_data_o), 64'(exp_words[i]));
      step();
    end
    reset_i      = 1'b1;
    dma_pkt_i    = {1'b0, 8'hFF, 30'h40};
    dma_pkt_v_i  = 1'b1;
    dma_data_v_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_val("midrst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
      check_val("midrst_data_v", 64'(dma_data_v_o), 64'd0);
      check_val("midrst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
      step();
    end
    reset_i      = 1'b0;
    dma_data_v_i = 1'b0;
    #1;
    check_val("post_rst_accept", 64'(dma_pkt_yumi_o), 64'd1);
    step();
    dma_pkt_v_i = 1'b0;
    read_words(1'b0, 0);
    @(negedge clk_i);

    // Back-to-back alternating write/read with dma_pkt_v_i held high.
    dma_pkt_v_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      logic wr;
      logic [DW-1:0] base_val;
      wr       = (p % 2) == 0;
      base_val = (p < 2) ? 32'h200 : 32'h300;
      dma_pkt_i        = {wr, 8'hFF, 30'hC0};
      dma_data_v_i     = 1'b1;
      dma_data_ready_i = 1'b1;
      dma_data_i       = 32'hDEAD;
      #1;
      check_val("b2b_accept", 64'(dma_pkt_yumi_o), 64'd1);
      check_val("b2b_accept_rd_v", 64'(dma_data_v_o), 64'd0);
      check_val("b2b_accept_yumi", 64'(dma_data_yumi_o), 64'd0);
      step();
      for (int i = 0; i < BS; i++) begin
        dma_data_i = base_val + 32'(i);
        #1;
        check_val("b2b_busy_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        if (wr) begin
          check_val("b2b_wr_yumi", 64'(dma_data_yumi_o), 64'd1);
        end else begin
          check_val("b2b_rd_ignores_v_i", 64'(dma_data_yumi_o), 64'd0);
          check_val("b2b_rd_data", 64'(dma_data_o), 64'(base_val + 32'(i)));
        end
        step();
      end
    end
    dma_pkt_v_i      = 1'b0;
    dma_data_v_i     = 1'b0;
    dma_data_ready_i = 1'b0;
    #1;
    check_val("final_idle_v", 64'(dma_data_v_o), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
